// File: rtl/parallel_finder.sv
// parallel_finder: index of the lowest-numbered set bit of a request vector.
// The combinational result comes from a binary reduction tree over the request
// bits, zero-padded up to a power of two.  A one-cycle registered copy of
// index/index_valid is provided for consumers with tight timing.
// Optional build macro: PARALLEL_FINDER_CHECK_EN adds simulation-only
// immediate assertions on the combinational outputs.
module parallel_finder #(
  parameter int WIDTH   = 4,
  parameter int INDEX_W = $clog2(WIDTH)  // derived; leave at default
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   data_in,
  output logic [INDEX_W-1:0] index,
  output logic               index_valid,
  output logic [WIDTH-1:0]   onehot,
  output logic [INDEX_W-1:0] index_r,
  output logic               index_valid_r
);

  localparam int PAD_W  = 1 << INDEX_W;
  localparam int LEAVES = PAD_W / 2;

  logic [PAD_W-1:0]   pad;
  logic [LEAVES-1:0]  tree_vld;
  logic [INDEX_W-1:0] tree_idx [LEAVES];
  logic [INDEX_W-1:0] index_r_d, index_r_q;
  logic               index_valid_r_d, index_valid_r_q;

  // Zero padding to a power of two; pad bits are never set so never win.
  assign pad = PAD_W'(data_in);

  // Reduction tree: pair leaves first, then combine pairs level by level.
  // Level b writes node n from nodes 2n/2n+1 of the previous level; since
  // 2n >= n, the in-place update never overwrites a node not yet consumed.
  // Bit b of a node index is set when the winner lives in the upper half.
  always_comb begin
    tree_vld = '0;
    for (int n = 0; n < LEAVES; n++) tree_idx[n] = '0;
    for (int n = 0; n < LEAVES; n++) begin
      tree_vld[n] = pad[2*n] | pad[2*n+1];
      tree_idx[n] = INDEX_W'(!pad[2*n]);
    end
    for (int b = 1; b < INDEX_W; b++) begin
      for (int n = 0; n < (PAD_W >> (b + 1)); n++) begin
        tree_idx[n] = tree_vld[2*n] ? tree_idx[2*n]
                                    : (tree_idx[2*n+1] | (INDEX_W'(1) << b));
        tree_vld[n] = tree_vld[2*n] | tree_vld[2*n+1];
      end
    end
  end

  // Root drives the outputs; an empty request reports index 0.
  assign index_valid = tree_vld[0];
  assign index       = tree_vld[0] ? tree_idx[0] : '0;

  // Isolate the lowest set bit directly (x & ~(x-1)); zero when x is zero.
  assign onehot = data_in & ~(data_in - WIDTH'(1));

  // Next-state for the registered copy is just the combinational result.
  always_comb begin
    index_r_d       = index;
    index_valid_r_d = index_valid;
  end

  // Registered copy with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      index_r_q       <= '0;
      index_valid_r_q <= 1'b0;
    end else begin
      index_r_q       <= index_r_d;
      index_valid_r_q <= index_valid_r_d;
    end
  end

  assign index_r       = index_r_q;
  assign index_valid_r = index_valid_r_q;

`ifdef PARALLEL_FINDER_CHECK_EN
  function automatic void check_finder(
    input logic [WIDTH-1:0]   d,
    input logic [INDEX_W-1:0] i,
    input logic               v,
    input logic [WIDTH-1:0]   oh
  );
    logic [WIDTH-1:0] below;
    logic [WIDTH-1:0] oh_exp;
    below  = (WIDTH'(1) << i) - WIDTH'(1);
    oh_exp = v ? (WIDTH'(1) << i) : '0;
    assert (v == (|d)) else $error("parallel_finder: index_valid wrong, data_in=%b", d);
    if (v) begin
      assert (d[i] == 1'b1) else $error("parallel_finder: selected bit clear, data_in=%b", d);
      assert ((d & below) == '0) else $error("parallel_finder: lower bit set, data_in=%b", d);
    end
    assert (oh == oh_exp) else $error("parallel_finder: onehot/index disagree, data_in=%b", d);
    assert ($countones(oh) <= 1) else $error("parallel_finder: onehot not one-hot, data_in=%b", d);
  endfunction

  // Check whenever the request vector (and thus the outputs) changes.
  always_comb check_finder(data_in, index, index_valid, onehot);

  // Check again on every clock edge.
  always @(posedge clk) check_finder(data_in, index, index_valid, onehot);
`endif

endmodule

// File: tb/tb_parallel_finder.sv
// Bench for parallel_finder at WIDTH=4, 5 (non power of two) and 8.
// Expected results come from a linear scan for the lowest set bit.
module tb_parallel_finder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] d4, oh4;  logic [1:0] i4, ir4;  logic v4, vr4;
  logic [4:0] d5, oh5;  logic [2:0] i5, ir5;  logic v5, vr5;
  logic [7:0] d8, oh8;  logic [2:0] i8, ir8;  logic v8, vr8;

  int vecs = 0;
  int errs = 0;

  parallel_finder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .data_in(d4), .index(i4), .index_valid(v4),
    .onehot(oh4), .index_r(ir4), .index_valid_r(vr4));
  parallel_finder #(.WIDTH(5)) u_w5 (
    .clk(clk), .rst(rst), .data_in(d5), .index(i5), .index_valid(v5),
    .onehot(oh5), .index_r(ir5), .index_valid_r(vr5));
  parallel_finder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .data_in(d8), .index(i8), .index_valid(v8),
    .onehot(oh8), .index_r(ir8), .index_valid_r(vr8));

  // Reference: position of the lowest set bit among the first w bits, -1 if none.
  function automatic int ref_lowest(input logic [7:0] v, input int w);
    for (int i = 0; i < w; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] ref_onehot(input logic [7:0] v, input int w);
    int r;
    r = ref_lowest(v, w);
    return (r < 0) ? 8'h00 : (8'h01 << r);
  endfunction

  function automatic int ref_index(input logic [7:0] v, input int w);
    int r;
    r = ref_lowest(v, w);
    return (r < 0) ? 0 : r;
  endfunction

  task automatic test_reset;
    rst = 1'b1; d4 = 4'b0110; d5 = 5'b11000; d8 = 8'h80;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if (ir4 !== 2'd0 || vr4 !== 1'b0 || ir5 !== 3'd0 || vr5 !== 1'b0 ||
        ir8 !== 3'd0 || vr8 !== 1'b0) begin
      errs++;
      $display("FAIL reset_regs got w4=%0d/%b w5=%0d/%b w8=%0d/%b want all 0",
               ir4, vr4, ir5, vr5, ir8, vr8);
    end
    // The combinational path ignores reset.
    vecs++;
    if (i4 !== 2'd1 || v4 !== 1'b1 || oh4 !== 4'b0010) begin
      errs++;
      $display("FAIL comb_in_reset got idx=%0d vld=%b oh=%b want idx=1 vld=1 oh=0010",
               i4, v4, oh4);
    end
  endtask

  task automatic test_directed;
    logic [3:0] tbl [8];
    tbl = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1110, 4'b1111, 4'b1010};
    for (int k = 0; k < 8; k++) begin
      d4 = tbl[k];
      #1;
      vecs++;
      if (i4 !== 2'(ref_index(8'(d4), 4)) || v4 !== (ref_lowest(8'(d4), 4) >= 0) ||
          oh4 !== 4'(ref_onehot(8'(d4), 4))) begin
        errs++;
        $display("FAIL directed_w4 data_in=%b got idx=%0d vld=%b oh=%b want idx=%0d oh=%b",
                 d4, i4, v4, oh4, ref_index(8'(d4), 4), 4'(ref_onehot(8'(d4), 4)));
      end
    end
  endtask

  task automatic test_exhaustive;
    for (int k = 0; k < 16; k++) begin
      d4 = 4'(k);
      #1;
      vecs++;
      if (i4 !== 2'(ref_index(8'(d4), 4)) || v4 !== (ref_lowest(8'(d4), 4) >= 0) ||
          oh4 !== 4'(ref_onehot(8'(d4), 4))) begin
        errs++;
        $display("FAIL sweep_w4 data_in=%b got idx=%0d vld=%b oh=%b", d4, i4, v4, oh4);
      end
    end
    for (int k = 0; k < 256; k++) begin
      d8 = 8'(k);
      #1;
      vecs++;
      if (i8 !== 3'(ref_index(d8, 8)) || v8 !== (ref_lowest(d8, 8) >= 0) ||
          oh8 !== ref_onehot(d8, 8)) begin
        errs++;
        $display("FAIL sweep_w8 data_in=%b got idx=%0d vld=%b oh=%b want idx=%0d oh=%b",
                 d8, i8, v8, oh8, ref_index(d8, 8), ref_onehot(d8, 8));
      end
    end
  endtask

  task automatic test_nonpow2;
    d5 = 5'b10000;
    #1;
    vecs++;
    if (i5 !== 3'd4 || v5 !== 1'b1 || oh5 !== 5'b10000) begin
      errs++;
      $display("FAIL w5_top_bit got idx=%0d vld=%b oh=%b want idx=4 vld=1 oh=10000", i5, v5, oh5);
    end
    d5 = 5'b00000;
    #1;
    vecs++;
    if (i5 !== 3'd0 || v5 !== 1'b0 || oh5 !== 5'b00000) begin
      errs++;
      $display("FAIL w5_empty got idx=%0d vld=%b oh=%b want idx=0 vld=0 oh=00000", i5, v5, oh5);
    end
    for (int k = 0; k < 40; k++) begin
      d5 = 5'($urandom_range(0, 31));
      #1;
      vecs++;
      if (i5 !== 3'(ref_index(8'(d5), 5)) || v5 !== (ref_lowest(8'(d5), 5) >= 0) ||
          oh5 !== 5'(ref_onehot(8'(d5), 5))) begin
        errs++;
        $display("FAIL random_w5 data_in=%b got idx=%0d vld=%b oh=%b", d5, i5, v5, oh5);
      end
    end
  endtask

  task automatic test_registered;
    @(negedge clk);
    d4 = 4'b0100; rst = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if (ir4 !== 2'd2 || vr4 !== 1'b1) begin
      errs++;
      $display("FAIL reg_first got idx_r=%0d vld_r=%b want idx_r=2 vld_r=1", ir4, vr4);
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      d4 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      d5 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      d8 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      @(posedge clk); #1;
      vecs++;
      if (ir4 !== 2'(ref_index(8'(d4), 4)) || vr4 !== (ref_lowest(8'(d4), 4) >= 0) ||
          ir5 !== 3'(ref_index(8'(d5), 5)) || vr5 !== (ref_lowest(8'(d5), 5) >= 0) ||
          ir8 !== 3'(ref_index(d8, 8))     || vr8 !== (ref_lowest(d8, 8) >= 0)) begin
        errs++;
        $display("FAIL reg_random d=%b/%b/%b got w4=%0d/%b w5=%0d/%b w8=%0d/%b",
                 d4, d5, d8, ir4, vr4, ir5, vr5, ir8, vr8);
      end
    end
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    d4 = 4'b1000; rst = 1'b1;
    @(posedge clk); #1;
    vecs++;
    if (ir4 !== 2'd0 || vr4 !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset_regs got idx_r=%0d vld_r=%b want 0/0", ir4, vr4);
    end
    vecs++;
    if (i4 !== 2'd3 || v4 !== 1'b1 || oh4 !== 4'b1000) begin
      errs++;
      $display("FAIL mid_reset_comb got idx=%0d vld=%b oh=%b want idx=3 vld=1 oh=1000",
               i4, v4, oh4);
    end
  endtask

  initial begin
    d4 = '0; d5 = '0; d8 = '0;
    test_reset();
    test_directed();
    test_exhaustive();
    test_nonpow2();
    test_registered();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/parallel_finder.md
Name: parallel_finder

Overview:
- Parallel priority finder. Reports the index of the lowest-numbered set bit of a WIDTH-bit request vector.
- Used throughout the core for free-slot, issue-slot and ready-entry selection.
- Main result is purely combinational, built as a log2(WIDTH)-deep binary reduction tree rather than a linear ripple chain.
- A one-cycle registered copy of the result is also provided for timing-critical consumers.

Parameters:
- WIDTH, 4, number of request bits; legal range 2..256, need not be a power of two.
- INDEX_W, $clog2(WIDTH), width of index outputs; derived, not to be overridden.

Ports:
- clk  input  1  system clock; only the registered outputs use it.
- rst  input  1  synchronous active-high reset.
- data_in  input  WIDTH  request vector; bit i set means entry i is a candidate.
- index  output  INDEX_W  combinational index of the lowest set bit of data_in.
- index_valid  output  1  combinational; 1 when any bit of data_in is set.
- onehot  output  WIDTH  combinational one-hot mask containing only the selected bit; all zeros when index_valid=0.
- index_r  output  INDEX_W  index registered on the rising clk edge.
- index_valid_r  output  1  index_valid registered on the rising clk edge.

Behaviour:
- Combinational outputs:
  - index, index_valid and onehot are pure functions of data_in, with zero latency.
  - They are independent of clk and rst, so they settle without any clock edge.
- Priority: the lowest index wins.
  - Example: data_in=4'b1010 gives index=1 and onehot=4'b0010.
- No bit set (data_in=0): index_valid=0, index=0, onehot=0.
- Tree structure:
  - Leaves are pairs of bits. Each node outputs valid = valid_lo | valid_hi.
  - Each node's index is {0, idx_lo} if valid_lo, else {1, idx_hi}.
  - Total depth is ceil(log2(WIDTH)).
- Non-power-of-two WIDTH: pad internally with zeros up to 2^INDEX_W bits. Padding bits are never selected.
- onehot is derived as data_in & ~(data_in - 1), or equivalently as a decode of index gated by index_valid. Both forms must agree.
- Registered outputs:
  - On each rising clk edge with rst=1: index_r <= 0 and index_valid_r <= 0.
  - With rst=0: index_r <= index and index_valid_r <= index_valid. Latency is exactly 1 cycle.
- Reset values: index_r=0 and index_valid_r=0. Combinational outputs have no reset value and always track data_in.
- If rst is asserted mid-operation, the registered outputs clear at the next edge; the combinational path is unaffected.
- Any X/Z on data_in propagates; there is no sanitisation.

Optional Feature:
- Macro PARALLEL_FINDER_CHECK_EN.
- When defined, the block contains simulation-only immediate assertions, evaluated on data_in changes and on each clk edge:
  - index_valid == |data_in.
  - If index_valid, then data_in[index]==1 and data_in[index-1:0]==0.
  - onehot == (index_valid ? 1<<index : 0).
  - $countones(onehot) <= 1.
  - Any failure calls $error with the data_in value.
- When not defined, no checker logic or assertions exist and functional behaviour is identical.

Test Plan:
- data_in=4'b0000, no clock -> index_valid=0, index=0, onehot=0.
- data_in=4'b0001, 4'b0010, 4'b0100, 4'b1000, no clock -> index_valid=1 and index=0,1,2,3 respectively; onehot equals data_in.
- data_in=4'b1110 -> index=1, onehot=4'b0010; data_in=4'b1111 -> index=0.
- Clocked: hold rst=1 for 2 cycles, then set data_in=4'b0100 and release rst -> after next edge index_r=2, index_valid_r=1; assert rst -> after next edge both are 0.
- WIDTH=5 (non-power-of-two): data_in=5'b10000 -> index=4; data_in=0 -> index_valid=0.
- Exhaustive sweep of all 2^WIDTH values for WIDTH=4 and 8 with PARALLEL_FINDER_CHECK_EN defined -> no assertion fires; index matches a linear reference model.
